// File: rtl/flash_read_responder.sv
// flash_read_responder: byte reads from Avalon-MM flash through a one-word cache with timeout
module flash_read_responder (
    input  logic        clk,
    input  logic        reset_all,
    input  logic        read_start,
    input  logic [20:0] addr_in,
    input  logic        cache_invalidate,
    output logic [7:0]  data_out,
    output logic        finish_read,
    output logic        read_error,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid
);
    typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT_DATA, DONE} state_t;
    state_t      r_state;
    state_t      w_next;
    logic        r_start_d;
    logic [20:0] r_addr;
    logic [9:0]  r_cnt;
    logic        r_cache_valid;
    logic [18:0] r_cache_tag;
    logic [31:0] r_cache_word;
    logic        w_rise;
    logic        w_busy;
    logic        w_hit;
    logic        w_accept;
    logic        w_timeout;
    logic        w_load;
    logic [7:0]  w_dout;

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] l);
        return w[{l, 3'b000} +: 8];
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (reset_all)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state logic; a coinciding invalidate turns a CHECK hit into a miss
    always_comb begin
        w_rise    = read_start && !r_start_d;
        w_busy    = (r_state == REQ) || (r_state == WAIT_DATA);
        w_hit     = r_cache_valid && (r_cache_tag == r_addr[20:2]) && !cache_invalidate;
        w_accept  = flash_mem_readdatavalid &&
                    (((r_state == REQ) && !flash_mem_waitrequest) || (r_state == WAIT_DATA));
        w_timeout = w_busy && !w_accept && (r_cnt == 10'h3ff);
        w_next    = r_state;
        case (r_state)
            IDLE:      w_next = w_rise ? CHECK : IDLE;
            CHECK:     w_next = w_hit ? DONE : REQ;
            REQ:       w_next = (w_accept || w_timeout) ? DONE :
                                !flash_mem_waitrequest ? WAIT_DATA : REQ;
            WAIT_DATA: w_next = (w_accept || w_timeout) ? DONE : WAIT_DATA;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // outputs decoded from state, plus the byte/error loaded on entry to DONE
    always_comb begin
        finish_read          = (r_state == DONE);
        flash_mem_read       = (r_state == REQ);
        flash_mem_address    = {4'b0000, r_addr[20:2]};
        flash_mem_byteenable = 4'b1111;
        w_load               = (w_next == DONE) && (r_state != DONE);
        w_dout               = w_accept  ? lane(flash_mem_readdata, r_addr[1:0]) :
                               w_timeout ? 8'h00 : lane(r_cache_word, r_addr[1:0]);
    end

    // datapath: edge detect, address capture, timeout counter, cache and result registers
    always_ff @(posedge clk) begin
        if (reset_all) begin
            r_start_d     <= 1'b0;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
            r_cache_word  <= '0;
            data_out      <= '0;
            read_error    <= 1'b0;
        end else begin
            r_start_d <= read_start;
            if ((r_state == IDLE) && w_rise)
                r_addr <= addr_in;
            r_cnt <= w_busy ? r_cnt + 10'd1 : 10'd0;
            if (w_accept) begin
                r_cache_valid <= 1'b1;
                r_cache_tag   <= r_addr[20:2];
                r_cache_word  <= flash_mem_readdata;
            end else if (cache_invalidate) begin
                r_cache_valid <= 1'b0;
            end
            if (w_load) begin
                data_out   <= w_dout;
                read_error <= w_timeout;
            end
        end
    end
endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: directed scenario tests for flash_read_responder
module tb_flash_read_responder;
    logic        clk = 1'b0;
    logic        reset_all = 1'b1;
    logic        read_start = 1'b0;
    logic [20:0] addr_in = '0;
    logic        cache_invalidate = 1'b0;
    logic [7:0]  data_out;
    logic        finish_read;
    logic        read_error;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b1;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          fin_count = 0;
    int          strobe_cycles = 0;
    int          acc_reads = 0;

    flash_read_responder dut (
        .clk(clk), .reset_all(reset_all), .read_start(read_start), .addr_in(addr_in),
        .cache_invalidate(cache_invalidate), .data_out(data_out), .finish_read(finish_read),
        .read_error(read_error), .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address), .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (finish_read) fin_count++;
        if (flash_mem_read) strobe_cycles++;
        if (flash_mem_read && !flash_mem_waitrequest) acc_reads++;
    end

    // Serves one bus read: stall wr cycles, accept, then return data the cycle after.
    // Returns at the DONE cycle (negedge) with ok=1, or ok=0 if no read strobe appeared.
    task automatic bus_serve(input int wr, input logic [31:0] d, input logic inv, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!flash_mem_read) return;
        repeat (wr) @(negedge clk);
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = d;
        cache_invalidate = inv;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        cache_invalidate = 1'b0;
        ok = 1'b1;
    endtask

    task automatic start_read(input logic [20:0] a);
        addr_in = a;
        read_start = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
    endtask

    task automatic test_reset;
        reset_all = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({data_out, finish_read, read_error, flash_mem_read} !== 11'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {data_out, finish_read, read_error, flash_mem_read});
        end
        checks++;
        if (flash_mem_address !== 23'h0) begin
            failures++;
            $display("FAIL reset_address got=%h want=0", flash_mem_address);
        end
        checks++;
        if (flash_mem_byteenable !== 4'hf) begin
            failures++;
            $display("FAIL byteenable got=%h want=f", flash_mem_byteenable);
        end
        reset_all = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_miss;
        logic ok;
        int r0 = acc_reads;
        start_read(21'h000005);
        bus_serve(2, 32'hA1B2C3D4, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL miss_strobe got=%b want=1", ok);
        end
        checks++;
        if (flash_mem_address !== 23'h000001) begin
            failures++;
            $display("FAIL miss_address got=%h want=000001", flash_mem_address);
        end
        checks++;
        if (acc_reads - r0 !== 1) begin
            failures++;
            $display("FAIL miss_read_count got=%0d want=1", acc_reads - r0);
        end
        checks++;
        if ({finish_read, data_out, read_error} !== {1'b1, 8'hC3, 1'b0}) begin
            failures++;
            $display("FAIL miss_done got=%b/%h/%b want=1/c3/0", finish_read, data_out, read_error);
        end
        @(negedge clk);
        checks++;
        if ({finish_read, data_out} !== {1'b0, 8'hC3}) begin
            failures++;
            $display("FAIL miss_after got=%b/%h want=0/c3", finish_read, data_out);
        end
    endtask

    task automatic test_hit;
        int s0 = strobe_cycles;
        addr_in = 21'h000007;
        read_start = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        checks++;
        if (finish_read !== 1'b0) begin
            failures++;
            $display("FAIL hit_t1 got=%b want=0", finish_read);
        end
        @(negedge clk);
        checks++;
        if ({finish_read, data_out} !== {1'b1, 8'hA1}) begin
            failures++;
            $display("FAIL hit_t2 got=%b/%h want=1/a1", finish_read, data_out);
        end
        @(negedge clk);
        checks++;
        if (strobe_cycles - s0 !== 0) begin
            failures++;
            $display("FAIL hit_no_bus got=%0d want=0", strobe_cycles - s0);
        end
    endtask

    task automatic test_invalidate;
        logic ok;
        cache_invalidate = 1'b1;
        @(negedge clk);
        cache_invalidate = 1'b0;
        start_read(21'h000004);
        bus_serve(0, 32'hA1B2C3D4, 1'b0, ok);
        checks++;
        if ({ok, finish_read, data_out} !== {1'b1, 1'b1, 8'hD4}) begin
            failures++;
            $display("FAIL invalidate_miss got=%b/%b/%h want=1/1/d4", ok, finish_read, data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_inv_check;
        logic ok;
        addr_in = 21'h000004;
        read_start = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        cache_invalidate = 1'b1;
        @(negedge clk);
        cache_invalidate = 1'b0;
        bus_serve(0, 32'h11223344, 1'b0, ok);
        checks++;
        if ({ok, finish_read, data_out} !== {1'b1, 1'b1, 8'h44}) begin
            failures++;
            $display("FAIL inv_check_miss got=%b/%b/%h want=1/1/44", ok, finish_read, data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_inv_fill;
        logic ok;
        int s0;
        start_read(21'h000008);
        bus_serve(1, 32'h55667788, 1'b1, ok);
        checks++;
        if ({ok, finish_read, data_out} !== {1'b1, 1'b1, 8'h88}) begin
            failures++;
            $display("FAIL inv_fill_read got=%b/%b/%h want=1/1/88", ok, finish_read, data_out);
        end
        @(negedge clk);
        s0 = strobe_cycles;
        start_read(21'h000009);
        @(negedge clk);
        checks++;
        if ({finish_read, data_out, strobe_cycles - s0} !== {1'b1, 8'h77, 32'd0}) begin
            failures++;
            $display("FAIL inv_fill_hit got=%b/%h/%0d want=1/77/0", finish_read, data_out, strobe_cycles - s0);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        logic ok;
        int n = 0;
        int s0 = strobe_cycles;
        start_read(21'h000010);
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        flash_mem_waitrequest = 1'b0;
        while (!finish_read && n < 1100) begin
            @(negedge clk);
            flash_mem_waitrequest = 1'b1;
            n++;
        end
        checks++;
        if (n !== 1024) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d want=1024", n);
        end
        checks++;
        if ({finish_read, data_out, read_error, flash_mem_read} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL timeout_done got=%b/%h/%b/%b want=1/00/1/0", finish_read, data_out, read_error, flash_mem_read);
        end
        checks++;
        if (strobe_cycles - s0 !== 1) begin
            failures++;
            $display("FAIL timeout_strobes got=%0d want=1", strobe_cycles - s0);
        end
        @(negedge clk);
        start_read(21'h000012);
        bus_serve(0, 32'hCAFEBABE, 1'b0, ok);
        checks++;
        if ({ok, finish_read, data_out, read_error} !== {1'b1, 1'b1, 8'hFE, 1'b0}) begin
            failures++;
            $display("FAIL timeout_recover got=%b/%b/%h/%b want=1/1/fe/0", ok, finish_read, data_out, read_error);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int f0 = fin_count;
        int r0;
        int n = 0;
        addr_in = 21'h000013;
        read_start = 1'b1;
        repeat (6) @(negedge clk);
        read_start = 1'b0;
        checks++;
        if ({fin_count - f0, data_out} !== {32'd1, 8'hCA}) begin
            failures++;
            $display("FAIL held_start got=%0d/%h want=1/ca", fin_count - f0, data_out);
        end
        @(negedge clk);
        f0 = fin_count;
        r0 = acc_reads;
        start_read(21'h000021);
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        read_start = 1'b1;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'h12345678;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        checks++;
        if ({finish_read, data_out} !== {1'b1, 8'h56}) begin
            failures++;
            $display("FAIL b2b_done got=%b/%h want=1/56", finish_read, data_out);
        end
        repeat (4) @(negedge clk);
        read_start = 1'b0;
        checks++;
        if ({fin_count - f0, acc_reads - r0} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL b2b_ignored got=%0d/%0d want=1/1", fin_count - f0, acc_reads - r0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int f0 = fin_count;
        int n = 0;
        start_read(21'h000031);
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        reset_all = 1'b1;
        @(negedge clk);
        reset_all = 1'b0;
        repeat (2) @(negedge clk);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hFFFFFFFF;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        @(negedge clk);
        checks++;
        if (fin_count - f0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_finish got=%0d want=0", fin_count - f0);
        end
        checks++;
        if ({data_out, read_error, flash_mem_read, flash_mem_address} !== 33'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h/%b/%b/%h want=0", data_out, read_error, flash_mem_read, flash_mem_address);
        end
    endtask

    task automatic test_start_after_reset;
        logic ok;
        int r0 = acc_reads;
        addr_in = 21'h000021;
        read_start = 1'b1;
        reset_all = 1'b1;
        @(negedge clk);
        reset_all = 1'b0;
        @(negedge clk);
        read_start = 1'b0;
        bus_serve(0, 32'h12345678, 1'b0, ok);
        checks++;
        if ({ok, finish_read, data_out, acc_reads - r0} !== {1'b1, 1'b1, 8'h56, 32'd1}) begin
            failures++;
            $display("FAIL start_after_reset got=%b/%b/%h/%0d want=1/1/56/1", ok, finish_read, data_out, acc_reads - r0);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_miss;
        test_hit;
        test_invalidate;
        test_inv_check;
        test_inv_fill;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_start_after_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
